// File: rtl/irq_controller.sv
// irq_controller: latches io interrupt events into a pending register, masks them, and presents
// one request at a time (lowest id first) to the CPU. Optional macro IRQ_OVF_DETECT_EN adds sticky ovf.
module irq_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq_in,
  input  logic [4:0]  irq_id,
  input  logic        wEn,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        cpu_irq,
  output logic [4:0]  cpu_irq_id,
  input  logic        cpu_ack,
  input  logic        cpu_done
);

  // state      | meaning
  // IDLE       | waiting for an eligible pending source
  // REQUEST    | cpu_irq high with cur_id, waiting for cpu_ack
  // IN_SERVICE | handler running, no new request until cpu_done
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pending, pending_nxt, mask, eligible;
  logic [4:0]  cur_id, winner;
  logic        irq_q;
  logic        ovf;
  logic        sel, wr_pend, wr_mask, set_ev;
  logic [1:0]  idx;
  logic        unused_addr_bits;

  assign sel              = addr[31:4] == BASE_ADDR[31:4];
  assign idx              = addr[3:2];
  assign wr_pend          = wEn && sel && (idx == 2'd0);
  assign wr_mask          = wEn && sel && (idx == 2'd1);
  assign set_ev           = irq_in && (irq_id != 5'd0);
  assign eligible         = pending & mask;
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    winner = 5'd0;
    for (int i = 31; i >= 1; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  // set beats both clear sources, so a same-cycle event on the acked id stays pending
  always_comb begin
    pending_nxt = pending;
    if (wr_pend) pending_nxt = pending_nxt & ~dataIn;
    if (state == REQUEST && cpu_ack) pending_nxt[cur_id] = 1'b0;
    if (set_ev) pending_nxt[irq_id] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
      mask    <= '0;
      cur_id  <= 5'd0;
    end else begin
      pending <= pending_nxt;
      if (wr_mask) mask <= dataIn;
      if (state == IDLE && eligible != '0) cur_id <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      irq_q <= 1'b0;
    end else begin
      state <= state_nxt;
      irq_q <= (state_nxt == REQUEST);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (eligible != '0) state_nxt = REQUEST;
      REQUEST:    if (cpu_ack)        state_nxt = IN_SERVICE;
      IN_SERVICE: if (cpu_done)       state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_irq    = irq_q;
    cpu_irq_id = cur_id;
  end

`ifdef IRQ_OVF_DETECT_EN
  logic wr_stat;
  assign wr_stat = wEn && sel && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n)                          ovf <= 1'b0;
    else if (set_ev && pending[irq_id])    ovf <= 1'b1;
    else if (wr_stat && dataIn[2])         ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    dataOut = '0;
    if (sel) begin
      case (idx)
        2'd0: dataOut = pending;
        2'd1: dataOut = mask;
        2'd2: dataOut = {27'b0, cur_id};
        2'd3: dataOut = {29'b0, ovf, state};
        default: dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios then randomized traffic, checked every cycle against a
// cycle-level behavioural model of the pending/mask/handshake rules.
module tb_irq_controller;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] PEND  = BASE;
  localparam logic [31:0] MASKA = BASE + 32'd4;
  localparam logic [31:0] CAUSE = BASE + 32'd8;
  localparam logic [31:0] STAT  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq_in = 1'b0;
  logic [4:0]  irq_id = 5'd0;
  logic        wEn = 1'b0;
  logic [31:0] addr = PEND;
  logic [31:0] dataIn = 32'd0;
  logic [31:0] dataOut;
  logic        cpu_irq;
  logic [4:0]  cpu_irq_id;
  logic        cpu_ack = 1'b0;
  logic        cpu_done = 1'b0;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 request outstanding, 2 handler running
  logic [31:0] m_pend, m_mask;
  logic [1:0]  m_state;
  logic [4:0]  m_cur;
  logic        m_ovf;

  irq_controller #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .irq_id(irq_id),
    .wEn(wEn), .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
    .cpu_irq(cpu_irq), .cpu_irq_id(cpu_irq_id), .cpu_ack(cpu_ack), .cpu_done(cpu_done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lowest(logic [31:0] v);
    for (int i = 1; i < 32; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: return {27'b0, m_cur};
      default: return {29'b0, m_ovf, m_state};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] np, nm;
    logic [1:0]  ns, ix;
    logic [4:0]  nc;
    logic        no, lsel, ev;
    lsel = addr[31:4] == BASE[31:4];
    ix   = addr[3:2];
    ev   = irq_in && irq_id != 5'd0;
    np = m_pend; nm = m_mask; ns = m_state; nc = m_cur; no = m_ovf;
    if (!reset_n) begin
      np = 0; nm = 0; ns = 0; nc = 0; no = 0;
    end else begin
      if (wEn && lsel && ix == 2'd0) np = np & ~dataIn;
      if (wEn && lsel && ix == 2'd1) nm = dataIn;
      case (m_state)
        2'd0: if ((m_pend & m_mask) != 0) begin ns = 1; nc = lowest(m_pend & m_mask); end
        2'd1: if (cpu_ack) begin ns = 2; np[m_cur] = 1'b0; end
        2'd2: if (cpu_done) ns = 0;
        default: ;
      endcase
`ifdef IRQ_OVF_DETECT_EN
      if (wEn && lsel && ix == 2'd3 && dataIn[2]) no = 1'b0;
      if (ev && m_pend[irq_id]) no = 1'b1;
`endif
      if (ev) np[irq_id] = 1'b1;
      np[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_mask = nm; m_state = ns; m_cur = nc; m_ovf = no;
    chk("cpu_irq", {31'b0, cpu_irq}, {31'b0, m_state == 2'd1});
    if (m_state == 2'd1) chk("cpu_irq_id", {27'b0, cpu_irq_id}, {27'b0, m_cur});
    chk("dataOut", dataOut, m_read(addr));
  endtask

  task automatic clr();
    irq_in = 0; irq_id = 0; wEn = 0; addr = PEND; dataIn = 0; cpu_ack = 0; cpu_done = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wEn = 1; addr = a; dataIn = d;
    tick();
    clr();
  endtask

  task automatic ev(input logic [4:0] id);
    irq_in = 1; irq_id = id;
    tick();
    clr();
  endtask

  task automatic rst();
    clr();
    reset_n = 0; addr = STAT;
    tick();
    reset_n = 1;
    clr();
  endtask

  initial begin
    m_pend = 0; m_mask = 0; m_state = 0; m_cur = 0; m_ovf = 0;

    // reset values
    rst();
    rst();
    addr = STAT; #1;
    chk("rst_status", dataOut, 32'd0);
    chk("rst_irq", {31'b0, cpu_irq}, 32'd0);
    chk("rst_irq_id", {27'b0, cpu_irq_id}, 32'd0);
    addr = MASKA; #1;
    chk("rst_mask", dataOut, 32'd0);
    clr();

    // 1: basic latency
    wr(MASKA, 32'h8);
    irq_in = 1; irq_id = 3; addr = PEND;
    tick();
    chk("t1_pend", dataOut, 32'h8);
    chk("t1_irq_early", {31'b0, cpu_irq}, 32'd0);
    clr();
    tick();
    chk("t1_irq", {31'b0, cpu_irq}, 32'd1);
    chk("t1_id", {27'b0, cpu_irq_id}, 32'd3);

    // 2: lowest id first
    rst();
    ev(5'd2);
    ev(5'd5);
    #1 chk("t2_pend", dataOut, 32'h24);
    wr(MASKA, 32'hffff_ffff);
    tick();
    chk("t2_first", {27'b0, cpu_irq_id}, 32'd2);
    cpu_ack = 1; tick(); clr();
    cpu_done = 1; tick(); clr();
    tick();
    chk("t2_second_irq", {31'b0, cpu_irq}, 32'd1);
    chk("t2_second", {27'b0, cpu_irq_id}, 32'd5);

    // 3: masked source, then unmask
    rst();
    ev(5'd7);
    tick(); tick();
    chk("t3_masked", {31'b0, cpu_irq}, 32'd0);
    chk("t3_pend", dataOut, 32'h80);
    wr(MASKA, 32'h80);
    tick();
    chk("t3_unmasked", {31'b0, cpu_irq}, 32'd1);
    chk("t3_id", {27'b0, cpu_irq_id}, 32'd7);

    // 4: event on acked id is kept and re-served
    rst();
    wr(MASKA, 32'h10);
    ev(5'd4);
    tick();
    chk("t4_req", {27'b0, cpu_irq_id}, 32'd4);
    cpu_ack = 1; irq_in = 1; irq_id = 4; addr = PEND;
    tick();
    chk("t4_pend_kept", dataOut, 32'h10);
    chk("t4_irq_low", {31'b0, cpu_irq}, 32'd0);
    clr();
    cpu_done = 1; tick(); clr();
    tick();
    chk("t4_reserve_irq", {31'b0, cpu_irq}, 32'd1);
    chk("t4_reserve_id", {27'b0, cpu_irq_id}, 32'd4);

    // 5: reset mid-service
    rst();
    wr(MASKA, 32'h2);
    ev(5'd1);
    tick();
    cpu_ack = 1; tick(); clr();
    addr = STAT; #1;
    chk("t5_in_service", dataOut, 32'd2);
    reset_n = 0; addr = STAT;
    tick();
    chk("t5_status", dataOut, 32'd0);
    chk("t5_irq", {31'b0, cpu_irq}, 32'd0);
    reset_n = 1; addr = PEND; #1;
    chk("t5_pend", dataOut, 32'd0);
    cpu_done = 1; addr = STAT;
    tick();
    chk("t5_done_ignored", dataOut, 32'd0);
    clr();

    // 6: overflow
    rst();
    ev(5'd9);
    ev(5'd9);
    addr = STAT; #1;
`ifdef IRQ_OVF_DETECT_EN
    chk("t6_ovf", dataOut, 32'h4);
`else
    chk("t6_ovf", dataOut, 32'h0);
`endif
    wr(STAT, 32'h4);
    addr = STAT; #1;
    chk("t6_ovf_clr", dataOut, 32'h0);
    clr();

    // randomized traffic
    rst();
    wr(MASKA, $urandom);
    for (int n = 0; n < 3000; n++) begin
      reset_n  = ($urandom_range(199) != 0);
      irq_in   = ($urandom_range(9) < 3);
      irq_id   = 5'($urandom_range(31));
      cpu_ack  = ($urandom_range(1) == 1);
      cpu_done = ($urandom_range(9) < 3);
      addr     = BASE | 32'($urandom_range(15));
      if ($urandom_range(9) == 0) addr = 32'h0000_3000 | 32'($urandom_range(15));
      wEn      = ($urandom_range(9) == 0);
      dataIn   = $urandom;
      if (wEn && addr[3:2] == 2'd0) dataIn = 32'h1 << $urandom_range(31);
      tick();
    end
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
